// File: rtl/pwr_ctrl.sv
// Power controller in front of the rail sequencer.
// Merges front-panel button presses and BMC requests into SYSEN, supervises SYSGOOD
// with timeout, bounded retry and a latched fault, and releases PERST_N after SYSGOOD.
module pwr_ctrl #(
   parameter int unsigned counter_size   = 24,
   parameter int unsigned t_debounce     = 20625,
   parameter int unsigned t_long_press   = 16500000,
   parameter int unsigned t_sysgood_wait = 8250000,
   parameter int unsigned t_reset_delay  = 412500,
   parameter int unsigned t_off_min      = 4125000,
   parameter int unsigned max_retry      = 1
) (
   input  logic       CLK_IN,
   input  logic       RST_N,
   input  logic       PWRBTN_N_A,
   input  logic       BMC_ON_REQ,
   input  logic       BMC_OFF_REQ,
   input  logic       SYSGOOD,
   output logic       SYSEN,
   output logic       PERST_N,
   output logic       FAULT,
   output logic [1:0] RETRY_CNT,
   output logic [2:0] PWR_STATE
);

   typedef enum logic [2:0] {
      StOff     = 3'd0,
      StPwrup   = 3'd1,
      StRstdly  = 3'd2,
      StOn      = 3'd3,
      StPwrdn   = 3'd4,
      StFailoff = 3'd5
   } state_e;

   localparam logic [counter_size-1:0] DebLast  = counter_size'(t_debounce - 1);
   localparam logic [counter_size-1:0] LongLast = counter_size'(t_long_press - 1);
   localparam logic [counter_size-1:0] SgWait   = counter_size'(t_sysgood_wait);
   localparam logic [counter_size-1:0] RstDly   = counter_size'(t_reset_delay);
   localparam logic [counter_size-1:0] OffMin   = counter_size'(t_off_min);
   localparam logic [counter_size-1:0] CntMax   = '1;
   localparam logic [1:0]              RetryMax = 2'(max_retry);

   // Button path state
   logic                    btn_meta_q, btn_sync_q;
   logic                    btn_pressed_q;
   logic [counter_size-1:0] deb_cnt_q;
   logic [counter_size-1:0] press_cnt_q;
   logic                    long_done_q;
   logic                    short_q, long_q;

   // Power FSM state
   state_e                  state_q;
   logic [counter_size-1:0] timer_q;
   logic                    sysen_q, perst_q, fault_q;
   logic [1:0]              retry_q;
   logic                    off_ok_q;

   // Decoded events
   logic btn_differs, btn_flip;
   logic on_ev, off_ev, off_ok;

   // Debounce decision and request decode; simultaneous BMC on/off resolves to off
   always_comb begin
      btn_differs = (btn_sync_q == btn_pressed_q);
      btn_flip    = btn_differs && (deb_cnt_q == DebLast);
      on_ev       = short_q | (BMC_ON_REQ & ~BMC_OFF_REQ);
      off_ev      = short_q | BMC_OFF_REQ;
      off_ok      = off_ok_q | (timer_q >= OffMin);
   end

   // Synchronize, debounce and classify button presses into SHORT / LONG pulses
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         btn_meta_q    <= 1'b1;
         btn_sync_q    <= 1'b1;
         btn_pressed_q <= 1'b0;
         deb_cnt_q     <= '0;
         press_cnt_q   <= '0;
         long_done_q   <= 1'b0;
         short_q       <= 1'b0;
         long_q        <= 1'b0;
      end else begin
         btn_meta_q <= PWRBTN_N_A;
         btn_sync_q <= btn_meta_q;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         if (btn_flip) begin
            btn_pressed_q <= ~btn_pressed_q;
            deb_cnt_q     <= '0;
         end else if (btn_differs) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end else begin
            deb_cnt_q <= '0;
         end
         if (btn_pressed_q) begin
            if (btn_flip) begin
               // Release: a press that already produced LONG yields nothing more
               short_q     <= ~long_done_q;
               long_done_q <= 1'b0;
               press_cnt_q <= '0;
            end else begin
               if (press_cnt_q != CntMax) press_cnt_q <= press_cnt_q + 1'b1;
               if ((press_cnt_q == LongLast) && !long_done_q) begin
                  long_q      <= 1'b1;
                  long_done_q <= 1'b1;
               end
            end
         end
      end
   end

   // Power sequencing FSM; shared timer restarts on every state change
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= StOff;
         timer_q  <= '0;
         sysen_q  <= 1'b0;
         perst_q  <= 1'b0;
         fault_q  <= 1'b0;
         retry_q  <= 2'd0;
         off_ok_q <= 1'b1;
      end else begin
         if (timer_q != CntMax) timer_q <= timer_q + 1'b1;
         unique case (state_q)
            StOff: begin
               sysen_q  <= 1'b0;
               perst_q  <= 1'b0;
               off_ok_q <= off_ok;
               if (on_ev && off_ok) begin
                  fault_q <= 1'b0;
                  retry_q <= 2'd0;
                  state_q <= StPwrup;
                  timer_q <= '0;
               end
            end
            StPwrup: begin
               sysen_q <= 1'b1;
               if (SYSGOOD) begin
                  state_q <= StRstdly;
                  timer_q <= '0;
               end else if (timer_q > SgWait) begin
                  sysen_q <= 1'b0;
                  perst_q <= 1'b0;
                  state_q <= StFailoff;
                  timer_q <= '0;
               end else if (off_ev || long_q) begin
                  sysen_q <= sysen_q;
                  perst_q <= 1'b0;
                  state_q <= StPwrdn;
                  timer_q <= '0;
               end
            end
            StRstdly: begin
               sysen_q <= 1'b1;
               if (!SYSGOOD) begin
                  sysen_q <= 1'b0;
                  perst_q <= 1'b0;
                  state_q <= StFailoff;
                  timer_q <= '0;
               end else if (off_ev || long_q) begin
                  perst_q <= 1'b0;
                  state_q <= StPwrdn;
                  timer_q <= '0;
               end else if (timer_q > RstDly) begin
                  perst_q <= 1'b1;
                  state_q <= StOn;
                  timer_q <= '0;
               end
            end
            StOn: begin
               sysen_q <= 1'b1;
               perst_q <= 1'b1;
               // Loss of SYSGOOD outranks a same-cycle off request
               if (!SYSGOOD) begin
                  sysen_q <= 1'b0;
                  perst_q <= 1'b0;
                  state_q <= StFailoff;
                  timer_q <= '0;
               end else if (off_ev || long_q) begin
                  perst_q <= 1'b0;
                  state_q <= StPwrdn;
                  timer_q <= '0;
               end
            end
            StPwrdn: begin
               sysen_q <= 1'b0;
               perst_q <= 1'b0;
               if (!SYSGOOD || (timer_q > SgWait)) begin
                  off_ok_q <= 1'b0;
                  state_q  <= StOff;
                  timer_q  <= '0;
               end
            end
            StFailoff: begin
               sysen_q <= 1'b0;
               perst_q <= 1'b0;
               if (long_q) begin
                  retry_q  <= 2'd0;
                  off_ok_q <= 1'b0;
                  state_q  <= StOff;
                  timer_q  <= '0;
               end else if (!SYSGOOD && (timer_q > OffMin)) begin
                  if (retry_q < RetryMax) begin
                     if (retry_q != 2'd3) retry_q <= retry_q + 2'd1;
                     state_q <= StPwrup;
                  end else begin
                     // Off time already served here, so a new request is taken at once
                     fault_q  <= 1'b1;
                     off_ok_q <= 1'b1;
                     state_q  <= StOff;
                  end
                  timer_q <= '0;
               end
            end
            default: begin
               sysen_q <= 1'b0;
               perst_q <= 1'b0;
               state_q <= StOff;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign SYSEN     = sysen_q;
   assign PERST_N   = perst_q;
   assign FAULT     = fault_q;
   assign RETRY_CNT = retry_q;
   assign PWR_STATE = state_q;

endmodule
